cpu_ctrl_seq: RTL and testbench

- Instruction-phase sequencer for the 8-clock-per-instruction 8-bit CPU.
- Drives `fetch` to the address multiplexer:
  - fetch=1 in phases 0-3 (PC address, instruction read from ROM).
  - fetch=0 in phases 4-7 (IR operand address, RAM/port access).
- Decodes the 3-bit opcode into per-phase strobes for PC, IR, accumulator, RAM read/write and the data-bus driver.
- Counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 42 ++++
 rtl/cpu_ctrl_decode.sv | 67 ++++++
 rtl/cpu_ctrl_seq.sv | 88 ++++++++
 tb/tb_cpu_ctrl_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-phase CPU controller: opcodes, state encoding
// and the strobe bundle passed from the decoder to the sequencer.
package cpu_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // P0..P7 are consecutive so the phase number is simply state - 1.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P0     = 4'd1,
        S_P1     = 4'd2,
        S_P2     = 4'd3,
        S_P3     = 4'd4,
        S_P4     = 4'd5,
        S_P5     = 4'd6,
        S_P6     = 4'd7,
        S_P7     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    typedef struct packed {
        logic fetch;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic rd;
        logic wr;
        logic datactl_ena;
        logic halt;
    } strobes_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Purely combinational decode of (state, opcode, zero) into the per-phase
// control strobes of the CPU datapath.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       zero,
    output strobes_t   strobes
);

    logic mem_op;
    logic is_sto;
    logic is_jmp;
    logic skip;

    assign mem_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);
    assign skip   = (opcode == OP_SKZ) && zero;

    always_comb begin
        strobes = '0;
        case (state)
            S_IDLE: strobes.fetch = 1'b1;
            S_P0: begin
                strobes.fetch   = 1'b1;
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
            end
            S_P1: begin
                strobes.fetch   = 1'b1;
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
                strobes.inc_pc  = 1'b1;
            end
            S_P2: strobes.fetch = 1'b1;
            S_P3: begin
                strobes.fetch  = 1'b1;
                strobes.inc_pc = (opcode != OP_HLT);
            end
            S_P4: begin
                strobes.load_pc     = is_jmp;
                strobes.rd          = mem_op;
                strobes.datactl_ena = is_sto;
            end
            // Skipping on zero is a second PC increment in P5 and again in P7.
            S_P5: begin
                strobes.rd          = mem_op;
                strobes.load_acc    = mem_op;
                strobes.wr          = is_sto;
                strobes.datactl_ena = is_sto;
                strobes.load_pc     = is_jmp;
                strobes.inc_pc      = is_jmp || skip;
            end
            S_P6: begin
                strobes.rd          = mem_op;
                strobes.datactl_ena = is_sto;
            end
            S_P7:     strobes.inc_pc = skip;
            S_HALTED: strobes.halt   = 1'b1;
            default:  strobes = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Instruction-phase sequencer: walks IDLE -> P0..P7 per instruction, stops in
// HALTED on HLT, and counts retired instructions.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             fetch,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             halt,
    output logic [2:0]       phase,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        phase_idx;
    strobes_t          strobes;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ena only matters at instruction boundaries; a started instruction always finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   state_d = ena ? S_P0 : S_IDLE;
            S_P0:     state_d = S_P1;
            S_P1:     state_d = S_P2;
            S_P2:     state_d = S_P3;
            S_P3:     state_d = (opcode == OP_HLT) ? S_HALTED : S_P4;
            S_P4:     state_d = S_P5;
            S_P5:     state_d = S_P6;
            S_P6:     state_d = S_P7;
            S_P7: begin
                state_d = ena ? S_P0 : S_IDLE;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    cpu_ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .zero    (zero),
        .strobes (strobes)
    );

    always_comb begin
        phase_idx = 4'(state_q) - 4'd1;
        busy      = (state_q >= S_P0) && (state_q <= S_P7);
        phase     = busy ? phase_idx[2:0] : 3'd0;
    end

    assign fetch       = strobes.fetch;
    assign load_ir     = strobes.load_ir;
    assign inc_pc      = strobes.inc_pc;
    assign load_pc     = strobes.load_pc;
    assign load_acc    = strobes.load_acc;
    assign rd          = strobes.rd;
    assign wr          = strobes.wr;
    assign datactl_ena = strobes.datactl_ena;
    assign halt        = strobes.halt;
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: each driven cycle queues the expected
// output vector, which a negedge monitor pops and compares.
module tb_cpu_ctrl_seq;

    localparam int CW = 4;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [2:0]    opcode;
    logic          zero;
    logic          fetch, load_ir, inc_pc, load_pc, load_acc;
    logic          rd, wr, datactl_ena, halt, busy;
    logic [2:0]    phase;
    logic [CW-1:0] instr_cnt;

    exp_t          sb_q[$];
    logic [CW-1:0] exp_cnt;
    int            n_checks = 0;
    int            n_errors = 0;

    cpu_ctrl_seq #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .fetch       (fetch),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .rd          (rd),
        .wr          (wr),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .phase       (phase),
        .busy        (busy),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput(e.tag, {fetch, load_ir, inc_pc, load_pc, load_acc, rd, wr,
                                datactl_ena, halt, busy, phase, instr_cnt}, e.val);
        end
    end

    // Order: fetch, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena.
    function automatic logic [7:0] exp_strobes(input logic [2:0] opc, input logic z, input int p);
        logic mem;
        mem = (opc == ADD) || (opc == 3'b011) || (opc == 3'b100) || (opc == LDA);
        case (p)
            0: return 8'b1100_0100;
            1: return 8'b1110_0100;
            2: return 8'b1000_0000;
            3: return (opc == HLT) ? 8'b1000_0000 : 8'b1010_0000;
            4: return (opc == JMP) ? 8'b0001_0000 : mem ? 8'b0000_0100 :
                      (opc == STO) ? 8'b0000_0001 : 8'b0000_0000;
            5: return (opc == JMP) ? 8'b0011_0000 : mem ? 8'b0000_1100 :
                      (opc == STO) ? 8'b0000_0011 :
                      ((opc == SKZ) && z) ? 8'b0010_0000 : 8'b0000_0000;
            6: return mem ? 8'b0000_0100 : (opc == STO) ? 8'b0000_0001 : 8'b0000_0000;
            7: return ((opc == SKZ) && z) ? 8'b0010_0000 : 8'b0000_0000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic idleCycle(input logic ena_v, input logic rst_v);
        exp_t e;
        @(posedge clk);
        #1;
        ena = ena_v;
        rst = rst_v;
        e.tag = "idle";
        e.val = {8'b1000_0000, 1'b0, 1'b0, 3'd0, exp_cnt};
        sb_q.push_back(e);
    endtask

    task automatic haltedCycle(input logic rst_v);
        exp_t e;
        @(posedge clk);
        #1;
        ena = 1'b1;
        rst = rst_v;
        e.tag = "halted";
        e.val = {8'b0000_0000, 1'b1, 1'b0, 3'd0, exp_cnt};
        sb_q.push_back(e);
    endtask

    // One instruction from P0; rst_phase >= 0 asserts reset during that phase.
    task automatic applyStimulus(input logic [2:0] opc, input logic z, input logic ena_mid,
                                 input logic ena_end, input int rst_phase, input string tag);
        exp_t e;
        for (int p = 0; p < 8; p++) begin
            @(posedge clk);
            #1;
            opcode = opc;
            zero   = z;
            ena    = (p == 7) ? ena_end : ena_mid;
            e.tag  = $sformatf("%s_p%0d", tag, p);
            e.val  = {exp_strobes(opc, z, p), 1'b0, 1'b1, 3'(p), exp_cnt};
            sb_q.push_back(e);
            if (p == rst_phase) begin
                rst     = 1'b1;
                exp_cnt = '0;
                return;
            end
            if (opc == HLT && p == 3) return;
        end
        exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        ena     = 1'b0;
        opcode  = 3'b000;
        zero    = 1'b0;
        exp_cnt = '0;

        idleCycle(1'b0, 1'b1);
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b0, 1'b0);
        idleCycle(1'b1, 1'b0);

        applyStimulus(LDA, 1'b0, 1'b1, 1'b1, -1, "lda");
        applyStimulus(STO, 1'b0, 1'b1, 1'b1, -1, "sto");
        applyStimulus(SKZ, 1'b1, 1'b1, 1'b1, -1, "skz_z1");
        applyStimulus(SKZ, 1'b0, 1'b1, 1'b1, -1, "skz_z0");
        applyStimulus(ADD, 1'b1, 1'b1, 1'b1, -1, "add");
        applyStimulus(JMP, 1'b0, 1'b1, 1'b1, -1, "jmp");
        applyStimulus(STO, 1'b0, 1'b1, 1'b1, 5, "sto_rst");
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b0, 1'b0);
        idleCycle(1'b1, 1'b0);

        applyStimulus(LDA, 1'b0, 1'b0, 1'b0, -1, "ena_drop");
        idleCycle(1'b0, 1'b0);
        idleCycle(1'b1, 1'b0);

        for (int i = 0; i < 16; i++)
            applyStimulus(LDA, 1'b0, 1'b1, (i != 15), -1, "wrap");
        idleCycle(1'b1, 1'b0);

        applyStimulus(JMP, 1'b0, 1'b1, 1'b1, -1, "jmp2");
        applyStimulus(HLT, 1'b0, 1'b1, 1'b1, -1, "hlt");
        for (int i = 0; i < 20; i++)
            haltedCycle(1'b0);
        haltedCycle(1'b1);
        exp_cnt = '0;
        idleCycle(1'b0, 1'b0);
        idleCycle(1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL drain got=%0d pending expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
